// File: rtl/mem_map_pkg.sv
// mem_map_pkg: MMIO addresses, STATUS bit layout and decode helper for the data memory responder
package mem_map_pkg;
    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_FF04;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FF08;
    localparam int ST_FULL  = 16;
    localparam int ST_EMPTY = 17;
    localparam int ST_OVF   = 18;
    localparam int CNT_W    = 16;
    function automatic logic word_hit(input logic [31:0] addr, input logic [31:0] target);
        return addr[31:2] == target[31:2];
    endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: processor data port plus TX stream handshake
interface data_mem_responder_if;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    modport master (
        output WE, address_to_mem, data_to_mem, tx_ready,
        input  data_from_mem, tx_data, tx_valid
    );
    modport slave (
        input  WE, address_to_mem, data_to_mem, tx_ready,
        output data_from_mem, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem_responder_tx_fifo.sv
// tx_fifo: transmit FIFO with push/pop arbitration and rejected-push reporting
module tx_fifo
    import mem_map_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [31:0]      din,
    input  logic             pop_ready,
    output logic [31:0]      dout,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             push_rejected
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          pop;
    logic          accept;
    assign empty         = cnt == '0;
    assign full          = cnt == CW'(FIFO_DEPTH);
    assign valid         = !empty;
    assign pop           = valid && pop_ready;
    // a full FIFO still takes a push when the head leaves on the same edge
    assign accept        = push && (!full || pop);
    assign push_rejected = push && !accept;
    assign dout          = valid ? mem[rd_ptr] : '0;
    assign count         = CNT_W'(cnt);
    // pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(accept) - CW'(pop);
        end
    end
    // storage is not reset; only entries below the count are ever visible
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM plus CYCLE/TXDATA/STATUS MMIO window for the single-cycle core
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]      ram [DEPTH];
    logic [31:0]      cycle_cnt;
    logic [31:0]      status;
    logic [AW-1:0]    idx;
    logic             is_ram;
    logic             is_cycle;
    logic             is_tx;
    logic             is_status;
    logic             ovf;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push_rejected;
    assign idx       = bus.address_to_mem[AW+1:2];
    assign is_ram    = bus.address_to_mem[31:AW+2] == '0;
    assign is_cycle  = word_hit(bus.address_to_mem, ADDR_CYCLE);
    assign is_tx     = word_hit(bus.address_to_mem, ADDR_TXDATA);
    assign is_status = word_hit(bus.address_to_mem, ADDR_STATUS);
    tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (bus.WE && is_tx),
        .din           (bus.data_to_mem),
        .pop_ready     (bus.tx_ready),
        .dout          (bus.tx_data),
        .valid         (bus.tx_valid),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .push_rejected (push_rejected)
    );
    // RAM write; a write coinciding with reset is discarded
    always_ff @(posedge clk) begin
        if (!reset && bus.WE && is_ram) ram[idx] <= bus.data_to_mem;
    end
    // free-running cycle counter, wraps at 2^32
    always_ff @(posedge clk) begin
        cycle_cnt <= reset ? '0 : cycle_cnt + 1'b1;
    end
    // sticky overflow: set by a rejected push, cleared by any STATUS write
    always_ff @(posedge clk) begin
        if (reset) ovf <= 1'b0;
        else if (bus.WE && is_status) ovf <= 1'b0;
        else if (push_rejected) ovf <= 1'b1;
    end
    // STATUS word assembly
    always_comb begin
        status               = '0;
        status[CNT_W-1:0]    = count;
        status[ST_FULL]      = full;
        status[ST_EMPTY]     = empty;
        status[ST_OVF]       = ovf;
    end
    // zero-latency read mux required by the single-cycle core
    always_comb begin
        bus.data_from_mem = is_ram ? ram[idx] : is_cycle ? cycle_cnt : is_status ? status : '0;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random checks of the data memory responder against a queue model
module tb_data_mem_responder;
    localparam int DEPTH = 64;
    localparam int FD    = 4;
    localparam logic [31:0] A_CYC = 32'hFFFF_FF00;
    localparam logic [31:0] A_TX  = 32'hFFFF_FF04;
    localparam logic [31:0] A_ST  = 32'hFFFF_FF08;
    logic clk;
    logic reset;
    data_mem_responder_if bus ();
    data_mem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mram [DEPTH];
    logic [31:0] q [$];
    bit          m_ovf;
    logic [31:0] m_cyc;
    logic [31:0] c_saved;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [31:0] s;
        if (a < DEPTH * 4) return mram[a[7:2]];
        if (a[31:2] == A_CYC[31:2]) return m_cyc;
        if (a[31:2] == A_ST[31:2]) begin
            s = 32'(q.size());
            if (q.size() == FD) s = s | 32'h0001_0000;
            if (q.size() == 0)  s = s | 32'h0002_0000;
            if (m_ovf)          s = s | 32'h0004_0000;
            return s;
        end
        return 32'h0;
    endfunction
    task automatic put(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        logic [31:0] e;
        bus.WE = we;
        bus.address_to_mem = a;
        bus.data_to_mem = d;
        bus.tx_ready = rdy;
        #1;
        e = exp_rd(a);
        if (!$isunknown(e)) chk("read", bus.data_from_mem, e);
        chk("tx_valid", 32'(bus.tx_valid), 32'(q.size() != 0));
        chk("tx_data", bus.tx_data, q.size() != 0 ? q[0] : 32'h0);
    endtask
    task automatic tick();
        bit pop;
        bit we;
        logic [31:0] a;
        logic [31:0] d;
        pop = q.size() != 0 && bus.tx_ready;
        we = bus.WE;
        a = bus.address_to_mem;
        d = bus.data_to_mem;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_ovf = 0;
            m_cyc = 0;
        end else begin
            m_cyc = m_cyc + 1;
            if (we && a < DEPTH * 4) mram[a[7:2]] = d;
            if (we && a[31:2] == A_ST[31:2]) m_ovf = 0;
            if (pop) q.delete(0);
            if (we && a[31:2] == A_TX[31:2]) begin
                if (q.size() < FD) q.push_back(d);
                else m_ovf = 1;
            end
        end
        #1;
    endtask
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        put(we, a, d, rdy);
        tick();
    endtask
    initial begin
        bus.WE = 0;
        bus.address_to_mem = 0;
        bus.data_to_mem = 0;
        bus.tx_ready = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        m_ovf = 0;
        m_cyc = 0;
        reset = 0;
        put(0, A_CYC, 0, 0);
        chk("cycle_at_0", bus.data_from_mem, 32'd0);
        chk("reset_valid", 32'(bus.tx_valid), 32'd0);
        chk("reset_txdata", bus.tx_data, 32'd0);
        put(0, A_ST, 0, 0);
        chk("reset_status", bus.data_from_mem, 32'h0002_0000);
        tick();
        repeat (4) step(0, 0, 0, 0);
        put(0, A_CYC, 0, 0);
        chk("cycle_at_5", bus.data_from_mem, 32'd5);
        tick();
        for (int i = 0; i < DEPTH; i++) step(1, 32'(i * 4), $urandom, 0);
        step(1, 32'h10, 32'hDEAD_BEEF, 0);
        put(0, 32'h10, 0, 0);
        chk("ram_rd", bus.data_from_mem, 32'hDEAD_BEEF);
        put(0, 32'h13, 0, 0);
        chk("ram_rd_unaligned", bus.data_from_mem, 32'hDEAD_BEEF);
        put(0, DEPTH * 4, 0, 0);
        chk("ram_out_of_range", bus.data_from_mem, 32'h0);
        tick();
        dut.cycle_cnt <= 32'hFFFF_FFFF;
        m_cyc = 32'hFFFF_FFFF;
        step(0, A_CYC, 0, 0);
        put(0, A_CYC, 0, 0);
        chk("cycle_wrap", bus.data_from_mem, 32'h0);
        c_saved = m_cyc;
        tick();
        step(1, A_CYC, 32'h1234_5678, 0);
        put(0, A_CYC, 0, 0);
        chk("cycle_write_ignored", bus.data_from_mem, c_saved + 2);
        tick();
        for (int k = 1; k <= 4; k++) step(1, A_TX, 32'(k), 0);
        put(0, A_ST, 0, 0);
        chk("fifo_full_status", bus.data_from_mem, 32'h0001_0004);
        tick();
        step(1, A_TX, 32'd5, 0);
        put(0, A_ST, 0, 0);
        chk("overflow_status", bus.data_from_mem, 32'h0005_0004);
        tick();
        for (int k = 1; k <= 4; k++) begin
            put(0, 0, 0, 1);
            chk("drain_valid", 32'(bus.tx_valid), 32'd1);
            chk("drain_data", bus.tx_data, 32'(k));
            tick();
        end
        put(0, A_ST, 0, 1);
        chk("drained_valid", 32'(bus.tx_valid), 32'd0);
        chk("drained_status", bus.data_from_mem, 32'h0006_0000);
        tick();
        step(1, A_ST, 32'hFFFF_FFFF, 0);
        put(0, A_ST, 0, 0);
        chk("ovf_cleared", bus.data_from_mem, 32'h0002_0000);
        tick();
        for (int k = 1; k <= 4; k++) step(1, A_TX, 32'(k), 0);
        step(1, A_TX, 32'd9, 1);
        put(0, A_ST, 0, 0);
        chk("full_push_pop_status", bus.data_from_mem, 32'h0001_0004);
        tick();
        for (int k = 0; k < 4; k++) begin
            put(0, 0, 0, 1);
            chk("pp_drain", bus.tx_data, k == 3 ? 32'd9 : 32'(k + 2));
            tick();
        end
        put(1, A_TX, 32'd7, 1);
        chk("empty_push_valid_same", 32'(bus.tx_valid), 32'd0);
        tick();
        put(0, 0, 0, 1);
        chk("empty_push_valid", 32'(bus.tx_valid), 32'd1);
        chk("empty_push_data", bus.tx_data, 32'd7);
        tick();
        put(0, 0, 0, 1);
        chk("empty_push_gone", 32'(bus.tx_valid), 32'd0);
        tick();
        for (int k = 1; k <= 5; k++) step(1, A_TX, 32'(k + 20), 0);
        step(0, 0, 0, 1);
        put(0, A_ST, 0, 0);
        chk("pre_reset_status", bus.data_from_mem, 32'h0004_0003);
        tick();
        reset = 1;
        step(1, 32'h10, 32'h0BAD_0BAD, 0);
        reset = 0;
        put(0, A_ST, 0, 0);
        chk("midreset_status", bus.data_from_mem, 32'h0002_0000);
        chk("midreset_valid", 32'(bus.tx_valid), 32'd0);
        put(0, A_CYC, 0, 0);
        chk("midreset_cycle", bus.data_from_mem, 32'd0);
        put(0, 32'h10, 0, 0);
        chk("midreset_ram_kept", bus.data_from_mem, 32'hDEAD_BEEF);
        tick();
        for (int n = 0; n < 500; n++) begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            a = sel < 4 ? 32'($urandom_range(0, DEPTH * 4 + 15)) :
                sel == 4 ? A_CYC | 32'($urandom_range(0, 3)) :
                sel < 7 ? A_TX : sel == 7 ? A_ST : 32'hFFFF_FF0C;
            reset = $urandom_range(0, 59) == 0;
            step(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2) == 0);
        end
        reset = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
